dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single-port 64K x 32 data memory between two requesters.
- Requester 0 is the CPU load/store path; requester 1 is the DMA/test loader-dumper.
- It accepts at most one access per two cycles, drives the memory's read/write address, write-enable and data lines from registered state, and returns read data with a valid pulse.
- Fixed CPU priority, with a starvation guard for DMA and an address-range check.

Parameters:
- ADDR_MAX, 65535, highest legal word address; accesses above it are blocked.
- MAX_WAIT, 8, number of lost arbitrations after which DMA wins the next one; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request, level, held until cpu_gnt seen
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  32  word address
- cpu_wdata  input  32  write data
- cpu_gnt  output  1  high for exactly the ACCESS cycle of a CPU access
- cpu_rvalid  output  1  one-cycle pulse, cpu_rdata valid
- cpu_rdata  output  32  read data
- cpu_err  output  1  one-cycle pulse with rvalid timing, out-of-range access
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err: same directions, widths and meaning as the cpu_* ports, for DMA
- mem_read_address  output  32  to memory read_address
- mem_write_address  output  32  to memory write_address
- mem_write_enable  output  1  to memory write_enable
- mem_data_in  output  32  to memory data_in
- mem_data_out  input  32  from memory data_out (combinational read)

Behaviour:
- FSM states: IDLE and ACCESS.
- IDLE, at a rising edge:
  - If either req is high, pick a winner; latch its we/addr/wdata and owner; go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - DMA wins if dma_req && (!cpu_req || wait_cnt >= MAX_WAIT).
  - Otherwise CPU wins if cpu_req.
- wait_cnt (8 bit):
  - Increments, saturating at 255, on each IDLE decision where dma_req is high and CPU wins.
  - Clears on a DMA grant, or whenever dma_req is low at a decision edge.
- ACCESS lasts exactly one cycle, then always returns to IDLE:
  - gnt of the owner is registered-high; the other gnt stays 0.
  - mem_read_address = mem_write_address = latched addr.
  - mem_data_in = latched wdata.
  - mem_write_enable = latched we && (addr <= ADDR_MAX). It is driven from flops only, so it is glitch-free; the memory is level-sensitive.
- At the edge ending ACCESS:
  - Owner's rdata <= (read && in range) ? mem_data_out : 0.
  - Owner's rvalid <= 1 for reads only.
  - Owner's err <= 1 if addr > ADDR_MAX, for both reads and writes; no write occurs.
  - rvalid and err last one cycle.
  - Non-owner rdata holds its last value.
- Latency:
  - Request sampled at edge k, gnt high in cycle k..k+1.
  - Memory access during that same cycle.
  - rvalid/rdata valid in cycle k+1..k+2.
  - Throughput is one access per 2 cycles.
- Handshake:
  - req must stay high until gnt is seen; req is ignored while in ACCESS.
  - A requester that does not want another access must drop req by the edge ending ACCESS.
  - If req is still high at the following IDLE edge, it is a new request.
  - we/addr/wdata must be stable while req is high and gnt is low.
- Simultaneous requests: CPU wins unless the starvation guard fires. After a DMA grant, wait_cnt = 0 and CPU priority resumes.
- Address width: all 32 address bits are compared against ADDR_MAX; there is no truncation or wrap-around.
- Reset (async, any time, including mid-ACCESS) returns everything to its idle value:
  - FSM to IDLE, wait_cnt 0.
  - All gnt/rvalid/err 0, rdata 0.
  - mem_write_enable 0 immediately; mem_* addresses and data 0.
  - An aborted access gives no rvalid, and a write in progress is not committed after reset.

Test Plan:
- CPU writes addr 2 data 14, then reads addr 2 -> cpu_gnt 1 cycle each, mem_write_enable high only in the write ACCESS cycle, read returns cpu_rdata 14 with cpu_rvalid one cycle after gnt.
- Both req high continuously (CPU reads addr 3, DMA reads addr 4), MAX_WAIT=4 -> grant pattern C,C,C,C,D,C,C,C,C,D...; DMA rdata equals mem[4]; gnt never overlaps.
- Only DMA requests, writes 25 words (addrs 2..26) back-to-back -> one grant per 2 cycles, 25 mem_write_enable pulses, wait_cnt stays 0.
- CPU write to 0x0001_0000 with data 0xDEAD -> mem_write_enable stays 0, cpu_err pulses; a subsequent read of 0x0001_0000 returns rdata 0 with cpu_err and cpu_rvalid.
- rst_n asserted mid-ACCESS of a DMA write -> mem_write_enable and dma_gnt drop asynchronously, no dma_rvalid; after release, the first req is granted from IDLE normally.
- No requests for 20 cycles -> all gnt/rvalid/err stay 0 and mem_write_enable stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port 64K x 32 data memory.
// CPU has fixed priority; DMA is guaranteed a grant after MAX_WAIT lost arbitrations.
module dmem_arbiter #(
  parameter logic [31:0] ADDR_MAX = 32'd65535,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] mem_read_address,
  output logic [31:0] mem_write_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_wait_cnt;
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_cpu_gnt;
  logic        r_dma_gnt;
  logic        r_mem_we;
  logic        r_cpu_rvalid;
  logic        r_dma_rvalid;
  logic        r_cpu_err;
  logic        r_dma_err;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dma_rdata;

  logic        w_dma_win;
  logic        w_cpu_win;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_in_range;
  logic [31:0] w_rd_data;

  always_comb begin
    w_dma_win   = dma_req && (!cpu_req || (r_wait_cnt >= LP_MAX_WAIT));
    w_cpu_win   = cpu_req && !w_dma_win;
    w_sel_we    = w_dma_win ? dma_we    : cpu_we;
    w_sel_addr  = w_dma_win ? dma_addr  : cpu_addr;
    w_sel_wdata = w_dma_win ? dma_wdata : cpu_wdata;
    w_in_range  = (r_addr <= ADDR_MAX);
    w_rd_data   = (!r_we && w_in_range) ? mem_data_out : '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_dma_win || w_cpu_win) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_gnt    <= 1'b0;
      r_dma_gnt    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_dma_err    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_cpu_gnt    <= 1'b0;
      r_dma_gnt    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_dma_err    <= 1'b0;
      if (r_state == S_IDLE) begin
        // dma_req high without a DMA win can only mean the CPU won
        if (!dma_req || w_dma_win)   r_wait_cnt <= '0;
        else if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
        if (w_dma_win || w_cpu_win) begin
          r_owner   <= w_dma_win;
          r_we      <= w_sel_we;
          r_addr    <= w_sel_addr;
          r_wdata   <= w_sel_wdata;
          r_cpu_gnt <= w_cpu_win;
          r_dma_gnt <= w_dma_win;
          r_mem_we  <= w_sel_we && (w_sel_addr <= ADDR_MAX);
        end
      end else begin
        if (r_owner) begin
          r_dma_rdata  <= w_rd_data;
          r_dma_rvalid <= !r_we;
          r_dma_err    <= !w_in_range;
        end else begin
          r_cpu_rdata  <= w_rd_data;
          r_cpu_rvalid <= !r_we;
          r_cpu_err    <= !w_in_range;
        end
      end
    end
  end

  assign cpu_gnt           = r_cpu_gnt;
  assign dma_gnt           = r_dma_gnt;
  assign cpu_rvalid        = r_cpu_rvalid;
  assign dma_rvalid        = r_dma_rvalid;
  assign cpu_err           = r_cpu_err;
  assign dma_err           = r_dma_err;
  assign cpu_rdata         = r_cpu_rdata;
  assign dma_rdata         = r_dma_rdata;
  assign mem_read_address  = r_addr;
  assign mem_write_address = r_addr;
  assign mem_data_in       = r_wdata;
  assign mem_write_enable  = r_mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 64K x 32 memory.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [31:0] mem_read_address, mem_write_address, mem_data_in, mem_data_out;
  logic        mem_write_enable;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:65535];

  dmem_arbiter #(.ADDR_MAX(32'd65535), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_enable(mem_write_enable), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (mem_write_enable && mem_write_address <= 32'd65535)
      mem[mem_write_address[15:0]] <= mem_data_in;

  assign mem_data_out = (mem_read_address <= 32'd65535) ? mem[mem_read_address[15:0]] : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one complete access on the chosen port, DUT assumed idle.
  task automatic drive_access(input bit is_dma, input bit we, input logic [31:0] addr,
                              input logic [31:0] data);
    if (is_dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = data; end
    else        begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = data; end
    step();
    cpu_req = 0;
    dma_req = 0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    #1;
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err, mem_write_enable} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err, mem_write_enable});
    end
    checks++;
    if ({cpu_rdata, dma_rdata, mem_read_address, mem_write_address, mem_data_in} !== 160'h0) begin
      failures++;
      $display("FAIL reset_data got=%h %h %h %h %h exp=0", cpu_rdata, dma_rdata,
               mem_read_address, mem_write_address, mem_data_in);
    end
    step();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_cpu_write_read();
    logic        v_we   [2] = '{1'b1, 1'b0};
    logic [31:0] v_addr [2] = '{32'd2, 32'd2};
    logic [31:0] v_data [2] = '{32'd14, 32'd0};
    logic [31:0] v_rd   [2] = '{32'd0, 32'd14};
    for (int i = 0; i < 2; i++) begin
      cpu_req = 1; cpu_we = v_we[i]; cpu_addr = v_addr[i]; cpu_wdata = v_data[i];
      step();
      checks++;
      if ({cpu_gnt, dma_gnt, mem_write_enable} !== {2'b10, v_we[i]}) begin
        failures++;
        $display("FAIL cwr_gnt[%0d] got=%b exp=%b", i, {cpu_gnt, dma_gnt, mem_write_enable}, {2'b10, v_we[i]});
      end
      checks++;
      if (mem_write_address !== v_addr[i] || mem_read_address !== v_addr[i]) begin
        failures++;
        $display("FAIL cwr_addr[%0d] got=%h/%h exp=%h", i, mem_write_address, mem_read_address, v_addr[i]);
      end
      cpu_req = 0;
      step();
      checks++;
      if ({cpu_gnt, mem_write_enable, cpu_rvalid, cpu_err} !== {2'b00, !v_we[i], 1'b0}) begin
        failures++;
        $display("FAIL cwr_done[%0d] got=%b exp=%b", i, {cpu_gnt, mem_write_enable, cpu_rvalid, cpu_err}, {2'b00, !v_we[i], 1'b0});
      end
      checks++;
      if (cpu_rdata !== v_rd[i]) begin
        failures++;
        $display("FAIL cwr_rdata[%0d] got=%h exp=%h", i, cpu_rdata, v_rd[i]);
      end
    end
    step();
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cwr_rvalid_pulse got=%b exp=0", cpu_rvalid);
    end
  endtask

  task automatic test_starvation();
    bit exp_dma;
    drive_access(0, 1, 32'd3, 32'h33);
    drive_access(0, 1, 32'd4, 32'h44);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'd3;
    dma_req = 1; dma_we = 0; dma_addr = 32'd4;
    for (int i = 0; i < 10; i++) begin
      exp_dma = (i % 5) == 4;
      step();
      checks++;
      if ({cpu_gnt, dma_gnt} !== {!exp_dma, exp_dma}) begin
        failures++;
        $display("FAIL starve_gnt[%0d] got=%b exp=%b", i, {cpu_gnt, dma_gnt}, {!exp_dma, exp_dma});
      end
      if (i == 9) begin cpu_req = 0; dma_req = 0; end
      step();
      checks++;
      if ({cpu_rvalid, dma_rvalid, cpu_gnt, dma_gnt} !== {!exp_dma, exp_dma, 2'b00}) begin
        failures++;
        $display("FAIL starve_rvalid[%0d] got=%b exp=%b", i, {cpu_rvalid, dma_rvalid, cpu_gnt, dma_gnt}, {!exp_dma, exp_dma, 2'b00});
      end
      checks++;
      if ((exp_dma ? dma_rdata : cpu_rdata) !== (exp_dma ? 32'h44 : 32'h33)) begin
        failures++;
        $display("FAIL starve_rdata[%0d] got=%h exp=%h", i, exp_dma ? dma_rdata : cpu_rdata, exp_dma ? 32'h44 : 32'h33);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 25; i++) begin
      dma_req = 1; dma_we = 1; dma_addr = 32'd2 + 32'(i); dma_wdata = 32'h100 + 32'(i);
      step();
      if (mem_write_enable) pulses++;
      checks++;
      if ({cpu_gnt, dma_gnt, mem_write_enable} !== 3'b011) begin
        failures++;
        $display("FAIL b2b_gnt[%0d] got=%b exp=011", i, {cpu_gnt, dma_gnt, mem_write_enable});
      end
      if (i == 24) dma_req = 0;
      step();
      if (mem_write_enable) pulses++;
      checks++;
      if ({dma_gnt, dma_rvalid, dma_err, dut.r_wait_cnt} !== 11'b0) begin
        failures++;
        $display("FAIL b2b_idle[%0d] got=%b exp=0", i, {dma_gnt, dma_rvalid, dma_err, dut.r_wait_cnt});
      end
    end
    checks++;
    if (pulses !== 25) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=25", pulses);
    end
    for (int i = 0; i < 25; i += 6) begin
      checks++;
      if (mem[2 + i] !== 32'h100 + 32'(i)) begin
        failures++;
        $display("FAIL b2b_mem[%0d] got=%h exp=%h", 2 + i, mem[2 + i], 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic        v_we   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] v_addr [5] = '{32'h0000_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] v_data [5] = '{32'h77, 32'hDEAD, 32'h0, 32'h0, 32'h0};
    logic        v_mwe  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        v_err  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] v_rd   [5] = '{32'h0, 32'h0, 32'h77, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      cpu_req = 1; cpu_we = v_we[i]; cpu_addr = v_addr[i]; cpu_wdata = v_data[i];
      step();
      checks++;
      if ({cpu_gnt, mem_write_enable} !== {1'b1, v_mwe[i]}) begin
        failures++;
        $display("FAIL oor_gnt[%0d] got=%b exp=%b", i, {cpu_gnt, mem_write_enable}, {1'b1, v_mwe[i]});
      end
      cpu_req = 0;
      step();
      checks++;
      if ({cpu_rvalid, cpu_err} !== {!v_we[i], v_err[i]} || cpu_rdata !== v_rd[i]) begin
        failures++;
        $display("FAIL oor_resp[%0d] got=%b/%h exp=%b/%h", i, {cpu_rvalid, cpu_err}, cpu_rdata,
                 {!v_we[i], v_err[i]}, v_rd[i]);
      end
    end
    step();
    checks++;
    if (cpu_err !== 1'b0) begin
      failures++;
      $display("FAIL oor_err_pulse got=%b exp=0", cpu_err);
    end
  endtask

  task automatic test_reset_mid_access();
    dma_req = 1; dma_we = 1; dma_addr = 32'd10; dma_wdata = 32'hBEEF;
    step();
    checks++;
    if ({dma_gnt, mem_write_enable} !== 2'b11) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=11", {dma_gnt, mem_write_enable});
    end
    dma_req = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({dma_gnt, mem_write_enable} !== 2'b00 || mem_write_address !== 32'h0) begin
      failures++;
      $display("FAIL rst_async got=%b/%h exp=00/0", {dma_gnt, mem_write_enable}, mem_write_address);
    end
    step();
    checks++;
    if ({dma_rvalid, dma_err} !== 2'b00 || mem[10] !== 32'h108) begin
      failures++;
      $display("FAIL rst_abort got=%b/%h exp=00/00000108", {dma_rvalid, dma_err}, mem[10]);
    end
    rst_n = 1;
    step();
    dma_req = 1; dma_we = 0; dma_addr = 32'd10;
    step();
    checks++;
    if ({cpu_gnt, dma_gnt, mem_write_enable} !== 3'b010) begin
      failures++;
      $display("FAIL rst_regrant got=%b exp=010", {cpu_gnt, dma_gnt, mem_write_enable});
    end
    dma_req = 0;
    step();
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h108) begin
      failures++;
      $display("FAIL rst_reread got=%b/%h exp=1/00000108", dma_rvalid, dma_rdata);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err, mem_write_enable} !== 7'b0) begin
        failures++;
        $display("FAIL idle[%0d] got=%b exp=0", i, {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err, mem_write_enable});
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_starvation();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_access();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
